// File: rtl/gato_nxn_ctrl.sv
// gato_nxn_ctrl: N x N tic-tac-toe controller (board, cursor, turns, legality, sequential win/draw scan).
// Define GATO_TIMEOUT_EN to enable the per-move timeout that forfeits the turn after TIMEOUT_CYCLES.
module gato_nxn_ctrl #(
  parameter int N              = 3,
  parameter int TIMEOUT_CYCLES = 50000000,
  localparam int CW = $clog2(N*N),
  localparam int LW = $clog2(2*N+2)
) (
  input  logic              clk,
  input  logic              botonRST,
  input  logic              botonContCasilla,
  input  logic              botonSelect,
  output logic [2*N*N-1:0]  board,
  output logic [CW-1:0]     cursor,
  output logic              turn,
  output logic              busy,
  output logic              juegoTerminado,
  output logic [1:0]        winner,
  output logic              illegal,
  output logic [CW:0]       moves
);

  localparam int NN = N*N;
  localparam int NL = 2*N+2;
  localparam logic [CW-1:0] LAST_CELL = CW'(NN-1);
  localparam logic [CW:0]   ALL_CELLS = (CW+1)'(NN);
  localparam logic [LW-1:0] LAST_LINE = LW'(NL-1);

  typedef enum logic [1:0] {PLAY, CHECK, DONE} state_t;

  state_t            state_reg, state_next;
  logic [2*NN-1:0]   board_reg, board_next;
  logic [CW-1:0]     cursor_reg, cursor_next;
  logic              turn_reg, turn_next;
  logic [1:0]        winner_reg, winner_next;
  logic              illegal_reg, illegal_next;
  logic [CW:0]       moves_reg, moves_next;
  logic [LW-1:0]     line_reg, line_next;
  logic              cont_prev_reg, sel_prev_reg;

  logic              cont_edge, sel_edge, accepted, tmo_expire, cur_empty;
  logic [1:0]        mark;
  logic [NN-1:0]     cell_mark, cell_empty;
  logic [NL-1:0]     line_hit;

  genvar gi, gk;

  assign cont_edge = botonContCasilla & ~cont_prev_reg;
  assign sel_edge  = botonSelect & ~sel_prev_reg;
  assign mark      = {turn_reg, ~turn_reg};

  for (gi = 0; gi < NN; gi++) begin : g_cell
    assign cell_mark[gi]  = (board_reg[2*gi +: 2] == mark);
    assign cell_empty[gi] = (board_reg[2*gi +: 2] == 2'b00);
  end

  // Lines: rows 0..N-1, columns N..2N-1, main diagonal 2N, anti-diagonal 2N+1.
  for (gi = 0; gi < NL; gi++) begin : g_line
    logic [N-1:0] bits;
    for (gk = 0; gk < N; gk++) begin : g_member
      localparam int IDX = (gi < N)     ? gi*N + gk :
                           (gi < 2*N)   ? gk*N + (gi - N) :
                           (gi == 2*N)  ? gk*N + gk :
                                          gk*N + (N - 1 - gk);
      assign bits[gk] = cell_mark[IDX];
    end
    assign line_hit[gi] = &bits;
  end

  assign cur_empty = cell_empty[cursor_reg];
  assign accepted  = (state_reg == PLAY) && sel_edge && cur_empty;

`ifdef GATO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_reg;

  assign tmo_expire = (state_reg == PLAY) && (tmo_reg == TMO_LAST);

  // Zero outside PLAY, so every entry into PLAY starts a fresh count.
  always_ff @(posedge clk) begin
    if (botonRST || state_reg != PLAY || accepted || tmo_expire) begin
      tmo_reg <= '0;
    end else begin
      tmo_reg <= tmo_reg + 1'b1;
    end
  end
`else
  assign tmo_expire = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    board_next   = board_reg;
    cursor_next  = cursor_reg;
    turn_next    = turn_reg;
    winner_next  = winner_reg;
    illegal_next = 1'b0;
    moves_next   = moves_reg;
    line_next    = line_reg;
    case (state_reg)
      PLAY: begin
        if (cont_edge) begin
          cursor_next = (cursor_reg == LAST_CELL) ? '0 : cursor_reg + 1'b1;
        end
        if (sel_edge) begin
          if (cur_empty) begin
            board_next[2*int'(cursor_reg) +: 2] = mark;
            moves_next = moves_reg + 1'b1;
            line_next  = '0;
            state_next = CHECK;
          end else begin
            illegal_next = 1'b1;
          end
        end
        if (tmo_expire && !accepted) begin
          turn_next = ~turn_reg;
        end
      end
      CHECK: begin
        if (line_hit[line_reg]) begin
          winner_next = mark;
          state_next  = DONE;
        end else if (line_reg == LAST_LINE) begin
          if (moves_reg == ALL_CELLS) begin
            winner_next = 2'b00;
            state_next  = DONE;
          end else begin
            turn_next  = ~turn_reg;
            state_next = PLAY;
          end
        end else begin
          line_next = line_reg + 1'b1;
        end
      end
      DONE: begin
      end
      default: state_next = PLAY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (botonRST) begin
      state_reg     <= PLAY;
      board_reg     <= '0;
      cursor_reg    <= '0;
      turn_reg      <= 1'b0;
      winner_reg    <= 2'b00;
      illegal_reg   <= 1'b0;
      moves_reg     <= '0;
      line_reg      <= '0;
      cont_prev_reg <= 1'b0;
      sel_prev_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      board_reg     <= board_next;
      cursor_reg    <= cursor_next;
      turn_reg      <= turn_next;
      winner_reg    <= winner_next;
      illegal_reg   <= illegal_next;
      moves_reg     <= moves_next;
      line_reg      <= line_next;
      cont_prev_reg <= botonContCasilla;
      sel_prev_reg  <= botonSelect;
    end
  end

  assign board          = board_reg;
  assign cursor         = cursor_reg;
  assign turn           = turn_reg;
  assign busy           = (state_reg == CHECK);
  assign juegoTerminado = (state_reg == DONE);
  assign winner         = winner_reg;
  assign illegal        = illegal_reg;
  assign moves          = moves_reg;

endmodule

// File: tb/tb_gato_nxn_ctrl.sv
// Scoreboard bench for gato_nxn_ctrl: an N=3 instance and an N=4 instance driven by directed move lists.
// Stimulus pushes expected snapshots; the negedge monitor pops one per observed DUT event and checks latency.
module tb_gato_nxn_ctrl;

  localparam int TMO = 200;

  typedef struct packed {
    logic [31:0] board;
    logic [4:0]  cursor;
    logic        turn;
    logic        busy;
    logic        done;
    logic [1:0]  winner;
    logic        illegal;
    logic [5:0]  moves;
  } snap_t;

  typedef struct {
    snap_t s;
    int    issue;
    int    lat;
    string nm;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst [2];
  logic cont [2];
  logic sel [2];
  int   cyc = 0;

  logic [17:0] board3;
  logic [3:0]  cursor3;
  logic        turn3, busy3, done3, illegal3;
  logic [1:0]  winner3;
  logic [4:0]  moves3;
  logic [31:0] board4;
  logic [3:0]  cursor4;
  logic        turn4, busy4, done4, illegal4;
  logic [1:0]  winner4;
  logic [4:0]  moves4;

  gato_nxn_ctrl #(.N(3), .TIMEOUT_CYCLES(TMO)) u_dut3 (
    .clk(clk), .botonRST(rst[0]), .botonContCasilla(cont[0]), .botonSelect(sel[0]),
    .board(board3), .cursor(cursor3), .turn(turn3), .busy(busy3), .juegoTerminado(done3),
    .winner(winner3), .illegal(illegal3), .moves(moves3)
  );

  gato_nxn_ctrl #(.N(4), .TIMEOUT_CYCLES(TMO)) u_dut4 (
    .clk(clk), .botonRST(rst[1]), .botonContCasilla(cont[1]), .botonSelect(sel[1]),
    .board(board4), .cursor(cursor4), .turn(turn4), .busy(busy4), .juegoTerminado(done4),
    .winner(winner4), .illegal(illegal4), .moves(moves4)
  );

  snap_t snap0, snap1;
  always_comb begin
    snap0 = '0;
    snap0.board = {14'd0, board3}; snap0.cursor = {1'b0, cursor3}; snap0.turn = turn3;
    snap0.busy = busy3; snap0.done = done3; snap0.winner = winner3; snap0.illegal = illegal3;
    snap0.moves = {1'b0, moves3};
  end
  always_comb begin
    snap1 = '0;
    snap1.board = board4; snap1.cursor = {1'b0, cursor4}; snap1.turn = turn4;
    snap1.busy = busy4; snap1.done = done4; snap1.winner = winner4; snap1.illegal = illegal4;
    snap1.moves = {1'b0, moves4};
  end

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model of game state, advanced by the stimulus tasks.
  logic [31:0] m_board [2];
  int          m_cursor [2];
  int          m_moves [2];
  logic        m_turn [2];
  logic        m_done [2];
  logic [1:0]  m_winner [2];

  int   probe_req [2];
  int   probe_ack [2];
  logic rst_q [2];
  logic [4:0] prev_cur [2];
  logic prev_busy [2];
  logic prev_turn [2];
  logic end_req = 1'b0;
  logic end_done = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_q[0] <= rst[0];
    rst_q[1] <= rst[1];
  end

  function automatic int nn(input int d);
    return (d == 0) ? 9 : 16;
  endfunction

  function automatic int nl(input int d);
    return (d == 0) ? 8 : 10;
  endfunction

  task automatic show_fail(input int d, input string nm, input snap_t a, input int la, input snap_t e, input int le);
    $display("FAIL dut%0d %s: got board=%h cur=%0d turn=%0d busy=%0d done=%0d win=%0d ill=%0d moves=%0d lat=%0d, want board=%h cur=%0d turn=%0d busy=%0d done=%0d win=%0d ill=%0d moves=%0d lat=%0d",
             d, nm, a.board, a.cursor, a.turn, a.busy, a.done, a.winner, a.illegal, a.moves, la,
             e.board, e.cursor, e.turn, e.busy, e.done, e.winner, e.illegal, e.moves, le);
  endtask

  task automatic mon(input int d, input snap_t a);
    logic ev;
    logic have;
    exp_t e;
    int   l;
    ev = (probe_req[d] != probe_ack[d]) ||
         (!rst_q[d] && (a.illegal || a.cursor != prev_cur[d] || (prev_busy[d] && !a.busy) || a.turn != prev_turn[d]));
    probe_ack[d] = probe_req[d];
    prev_cur[d]  = a.cursor;
    prev_busy[d] = a.busy;
    prev_turn[d] = a.turn;
    if (ev) begin
      checks++;
      have = 1'b0;
      if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      if (!have) begin
        failures++;
        $display("FAIL dut%0d unexpected_event: got board=%h cur=%0d turn=%0d busy=%0d ill=%0d, want no event",
                 d, a.board, a.cursor, a.turn, a.busy, a.illegal);
      end else begin
        l = cyc - e.issue;
        if (a !== e.s || l != e.lat) begin
          failures++;
          show_fail(d, e.nm, a, l, e.s, e.lat);
        end else begin
          $display("ok   dut%0d %-12s board=%h cur=%0d turn=%0d win=%0d moves=%0d lat=%0d",
                   d, e.nm, a.board, a.cursor, a.turn, a.winner, a.moves, l);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, snap0);
    mon(1, snap1);
    if (end_req && !end_done) begin
      while (q0.size() > 0) begin
        exp_t e;
        e = q0.pop_front();
        checks++; failures++;
        $display("FAIL dut0 %s: got no event, want event at lat=%0d", e.nm, e.lat);
      end
      while (q1.size() > 0) begin
        exp_t e;
        e = q1.pop_front();
        checks++; failures++;
        $display("FAIL dut1 %s: got no event, want event at lat=%0d", e.nm, e.lat);
      end
      end_done = 1'b1;
    end
  end

  task automatic push(input int d, input string nm, input int lat, input logic ill, input logic bsy);
    exp_t e;
    e.s.board   = m_board[d];
    e.s.cursor  = 5'(m_cursor[d]);
    e.s.turn    = m_turn[d];
    e.s.busy    = bsy;
    e.s.done    = m_done[d];
    e.s.winner  = m_winner[d];
    e.s.illegal = ill;
    e.s.moves   = 6'(m_moves[d]);
    e.issue = cyc;
    e.lat   = lat;
    e.nm    = nm;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic mreset(input int d);
    m_board[d] = '0; m_cursor[d] = 0; m_moves[d] = 0;
    m_turn[d] = 1'b0; m_done[d] = 1'b0; m_winner[d] = 2'b00;
  endtask

  task automatic probe(input int d, input string nm, input logic bsy);
    push(d, nm, 0, 1'b0, bsy);
    probe_req[d]++;
    @(posedge clk); #1;
  endtask

  task automatic rst_dut(input int d);
    rst[d] = 1'b1;
    @(posedge clk); #1;
    rst[d] = 1'b0;
    mreset(d);
    probe(d, "reset", 1'b0);
  endtask

  task automatic press_cont(input int d);
    cont[d] = 1'b1;
    if (!m_done[d]) begin
      m_cursor[d] = (m_cursor[d] + 1) % nn(d);
      push(d, $sformatf("cursor->%0d", m_cursor[d]), 1, 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    cont[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic goto_cell(input int d, input int c);
    while (m_cursor[d] != c) press_cont(d);
  endtask

  // hl: index of the line the scan should hit for this move, or -1 when none completes.
  task automatic press_sel(input int d, input int hl);
    int c;
    int lat;
    logic [1:0] mk;
    c = m_cursor[d];
    lat = 1;
    sel[d] = 1'b1;
    if (!m_done[d]) begin
      if (m_board[d][2*c +: 2] != 2'b00) begin
        push(d, $sformatf("illegal@%0d", c), 1, 1'b1, 1'b0);
      end else begin
        mk = m_turn[d] ? 2'b10 : 2'b01;
        m_board[d][2*c +: 2] = mk;
        m_moves[d]++;
        if (hl >= 0) begin
          lat = hl + 2;
          m_winner[d] = mk;
          m_done[d] = 1'b1;
        end else begin
          lat = nl(d) + 1;
          if (m_moves[d] == nn(d)) m_done[d] = 1'b1;
          else m_turn[d] = ~m_turn[d];
        end
        push(d, $sformatf("move@%0d", c), lat, 1'b0, 1'b0);
      end
    end
    @(posedge clk); #1;
    sel[d] = 1'b0;
    repeat (lat) @(posedge clk);
    #1;
  endtask

  task automatic play(input int d, input int c, input int hl);
    goto_cell(d, c);
    press_sel(d, hl);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; cont[d] = 1'b0; sel[d] = 1'b0;
      probe_req[d] = 0; probe_ack[d] = 0;
      prev_cur[d] = '0; prev_busy[d] = 1'b0; prev_turn[d] = 1'b0;
      mreset(d);
    end
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    probe(0, "reset", 1'b0);
    probe(1, "held_reset", 1'b0);

    // Cursor stepping with wrap, then a held level advancing only once.
    for (int i = 0; i < 10; i++) press_cont(0);
    cont[0] = 1'b1;
    m_cursor[0] = (m_cursor[0] + 1) % 9;
    push(0, "hold_adv", 1, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    cont[0] = 1'b0;
    @(posedge clk); #1;
    probe(0, "hold_end", 1'b0);

    // Row 0 win by player 1 against player 2 on cells 3 and 4.
    rst_dut(0);
    play(0, 0, -1); play(0, 3, -1); play(0, 1, -1); play(0, 4, -1);
    play(0, 2, 0);

    // Second select on an occupied cell.
    rst_dut(0);
    play(0, 4, -1);
    press_sel(0, -1);
    probe(0, "after_illegal", 1'b0);

    // Full-board draw, then buttons ignored in DONE.
    rst_dut(0);
    play(0, 0, -1); play(0, 1, -1); play(0, 2, -1); play(0, 4, -1); play(0, 3, -1);
    play(0, 5, -1); play(0, 7, -1); play(0, 6, -1); play(0, 8, -1);
    press_sel(0, -1);
    press_cont(0);
    probe(0, "done_frozen", 1'b0);

    // Anti-diagonal win by player 1.
    rst_dut(0);
    play(0, 2, -1); play(0, 0, -1); play(0, 4, -1); play(0, 1, -1);
    play(0, 6, 7);

    // N=4 column-3 win by player 2.
    rst_dut(1);
    play(1, 0, -1); play(1, 3, -1); play(1, 1, -1); play(1, 7, -1);
    play(1, 2, -1); play(1, 11, -1); play(1, 4, -1);
    play(1, 15, 7);

    // Reset asserted while the scan is running.
    rst_dut(0);
    goto_cell(0, 4);
    sel[0] = 1'b1;
    m_board[0][9:8] = 2'b01;
    m_moves[0] = 1;
    @(posedge clk); #1;
    sel[0] = 1'b0;
    probe(0, "mid_check", 1'b1);
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    mreset(0);
    probe(0, "abort_reset", 1'b0);

    // Idle in PLAY: forfeit with the timeout build, no change otherwise.
    rst_dut(0);
`ifdef GATO_TIMEOUT_EN
    m_turn[0] = 1'b1;
    push(0, "timeout", TMO - 1, 1'b0, 1'b0);
    repeat (TMO + 2) @(posedge clk);
    #1;
    rst_dut(0);
`else
    repeat (40) @(posedge clk);
    #1;
    probe(0, "no_timeout", 1'b0);
`endif

    repeat (4) @(posedge clk);
    #1;
    end_req = 1'b1;
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
